bigmul_arbiter: RTL and testbench

- Shares one bigmul_unit_csa instance among NUM_REQ requesters (core, DMA, accelerator ports).
- Selects a requester round-robin, steers the operand/result mux with mul_sel, pulses mul_start, and waits for mul_done.
- Returns completion, cycle count and error status to the winning requester; guards against a hung unit with a watchdog.

---
 rtl/bigmul_pkg.sv | 8 +
 rtl/bigmul_arbiter_rr_arbiter.sv | 28 ++
 rtl/bigmul_arbiter.sv | 119 +++++++++++
 tb/tb_bigmul_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bigmul_pkg.sv
// Shared types and constants for the bigmul unit and its requester arbiter.
package bigmul_pkg;
    localparam int NUM_LIMBS = 64;
    localparam int LIMB_W    = 64;
    localparam int CYC_W     = 64;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;
endpackage

// File: rtl/bigmul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: rotate so last+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any,
    output logic [ID_W-1:0]    winner
);
    logic [NUM_REQ-1:0] rot;
    int                 base;
    int                 pos;

    always_comb begin
        base = (int'(last) + 1) % NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[(base + i) % NUM_REQ];
        end
        pos = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = i;
        end
        any    = |rot;
        winner = ID_W'((base + pos) % NUM_REQ);
    end
endmodule

// File: rtl/bigmul_arbiter.sv
// Round-robin owner of a single shared bigmul unit: grant, start, wait for
// done (or watchdog abort), then pulse a one-hot response to the owner.
module bigmul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CYC_W   = bigmul_pkg::CYC_W,
    parameter int TIMEOUT = 65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] resp_valid,
    output logic               resp_err,
    output logic [CYC_W-1:0]   resp_cycles,
    output logic               grant_valid,
    output logic [ID_W-1:0]    mul_sel,
    output logic               mul_start,
    input  logic               mul_busy,
    input  logic               mul_done,
    input  logic [CYC_W-1:0]   mul_cycles,
    output logic [31:0]        jobs_done
);
    import bigmul_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  mul_sel_q, mul_sel_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic             grant_valid_q, grant_valid_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             resp_err_q, resp_err_d;
    logic [CYC_W-1:0] resp_cycles_q, resp_cycles_d;
    logic [31:0]      jobs_done_q, jobs_done_d;

    logic             any;
    logic [ID_W-1:0]  winner;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req    (req_valid),
        .last   (last_q),
        .any    (any),
        .winner (winner)
    );

    always_comb begin
        state_d       = state_q;
        mul_sel_d     = mul_sel_q;
        last_d        = last_q;
        grant_valid_d = grant_valid_q;
        wd_d          = wd_q;
        resp_err_d    = resp_err_q;
        resp_cycles_d = resp_cycles_q;
        jobs_done_d   = jobs_done_q;
        case (state_q)
            IDLE: begin
                if (any && !mul_busy) begin
                    mul_sel_d     = winner;
                    grant_valid_d = 1'b1;
                    state_d       = START;
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                // A done landing on the timeout cycle still counts as success.
                if (mul_done) begin
                    resp_cycles_d = mul_cycles;
                    resp_err_d    = 1'b0;
                    state_d       = RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    resp_cycles_d = '0;
                    resp_err_d    = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                jobs_done_d   = jobs_done_q + 32'd1;
                last_d        = mul_sel_q;
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mul_sel_q     <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
            grant_valid_q <= 1'b0;
            wd_q          <= '0;
            resp_err_q    <= 1'b0;
            resp_cycles_q <= '0;
            jobs_done_q   <= '0;
        end else begin
            state_q       <= state_d;
            mul_sel_q     <= mul_sel_d;
            last_q        <= last_d;
            grant_valid_q <= grant_valid_d;
            wd_q          <= wd_d;
            resp_err_q    <= resp_err_d;
            resp_cycles_q <= resp_cycles_d;
            jobs_done_q   <= jobs_done_d;
        end
    end

    assign resp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << mul_sel_q) : '0;
    assign mul_start   = (state_q == START);
    assign mul_sel     = mul_sel_q;
    assign grant_valid = grant_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_cycles = resp_cycles_q;
    assign jobs_done   = jobs_done_q;
endmodule

// File: tb/tb_bigmul_arbiter.sv
// Directed bench: main instance (TIMEOUT=256) plus a TIMEOUT=16 instance for watchdog cases.
module tb_bigmul_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_w;
    logic        mul_busy, mul_done;
    logic [63:0] mul_cycles;

    logic [3:0]  resp_valid, w_resp_valid;
    logic        resp_err, w_resp_err;
    logic [63:0] resp_cycles, w_resp_cycles;
    logic        grant_valid, w_grant_valid;
    logic [1:0]  mul_sel, w_mul_sel;
    logic        mul_start, w_mul_start;
    logic [31:0] jobs_done, w_jobs_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bigmul_arbiter #(.NUM_REQ(4), .CYC_W(64), .TIMEOUT(256)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_cycles(resp_cycles), .grant_valid(grant_valid),
        .mul_sel(mul_sel), .mul_start(mul_start), .mul_busy(mul_busy),
        .mul_done(mul_done), .mul_cycles(mul_cycles), .jobs_done(jobs_done)
    );

    bigmul_arbiter #(.NUM_REQ(4), .CYC_W(64), .TIMEOUT(16)) dut_wd (
        .clk(clk), .rst(rst), .req_valid(req_w), .resp_valid(w_resp_valid),
        .resp_err(w_resp_err), .resp_cycles(w_resp_cycles), .grant_valid(w_grant_valid),
        .mul_sel(w_mul_sel), .mul_start(w_mul_start), .mul_busy(mul_busy),
        .mul_done(mul_done), .mul_cycles(mul_cycles), .jobs_done(w_jobs_done)
    );

    // Negedges until the chosen instance shows mul_start; -1 if it never does.
    task automatic wait_start(input bit wd, output int n);
        n = 0;
        while (!(wd ? w_mul_start : mul_start) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!(wd ? w_mul_start : mul_start)) n = -1;
    endtask

    // From the START negedge: pulse mul_done after 'after' cycles; returns at the RESP negedge.
    task automatic do_done(input int after, input logic [63:0] cv);
        repeat (after) @(negedge clk);
        mul_done = 1'b1; mul_cycles = cv;
        @(negedge clk);
        mul_done = 1'b0; mul_cycles = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_w = '0; mul_busy = 1'b0; mul_done = 1'b0; mul_cycles = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant got %b exp 0", grant_valid); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", mul_start); end
        checks++; if (mul_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", mul_sel); end
        checks++; if (jobs_done !== 32'd0) begin errors++; $display("FAIL reset_jobs got %0d exp 0", jobs_done); end
        checks++; if (resp_cycles !== 64'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got %0d/%b exp 0/0", resp_cycles, resp_err); end
    endtask

    task automatic test_single();
        int n;
        req_valid = 4'b0001;
        wait_start(1'b0, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", n); end
        checks++; if (mul_sel !== 2'd0 || grant_valid !== 1'b1) begin errors++; $display("FAIL single_grant got sel %0d gv %b exp 0 1", mul_sel, grant_valid); end
        do_done(100, 64'd100);
        checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_resp got %b exp 0001", resp_valid); end
        checks++; if (resp_cycles !== 64'd100 || resp_err !== 1'b0) begin errors++; $display("FAIL single_cycles got %0d/%b exp 100/0", resp_cycles, resp_err); end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL single_pulse got %b exp 0000", resp_valid); end
        checks++; if (jobs_done !== 32'd1 || grant_valid !== 1'b0) begin errors++; $display("FAIL single_jobs got %0d gv %b exp 1 0", jobs_done, grant_valid); end
        checks++; if (mul_sel !== 2'd0) begin errors++; $display("FAIL single_sel_hold got %0d exp 0", mul_sel); end
    endtask

    task automatic test_fairness();
        int n;
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            req_valid = 4'b1111;
            for (int k = 0; k < 4; k++) begin
                wait_start(1'b0, n);
                checks++; if (n !== ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL fair_latency r%0d k%0d got %0d exp %0d", r, k, n, (k == 0) ? 1 : 2); end
                checks++; if (mul_sel !== 2'(k)) begin errors++; $display("FAIL fair_order r%0d got %0d exp %0d", r, mul_sel, k); end
                do_done(3, 64'(10 + k));
                checks++; if (resp_valid !== (4'b0001 << k)) begin errors++; $display("FAIL fair_resp r%0d got %b exp owner %0d", r, resp_valid, k); end
                checks++; if (resp_cycles !== 64'(10 + k)) begin errors++; $display("FAIL fair_cycles got %0d exp %0d", resp_cycles, 10 + k); end
                req_valid[k] = 1'b0;
            end
            @(negedge clk);
            checks++; if (jobs_done !== 32'(4 * (r + 1))) begin errors++; $display("FAIL fair_jobs got %0d exp %0d", jobs_done, 4 * (r + 1)); end
        end
    endtask

    task automatic test_rotation();
        int n;
        req_valid = 4'b0100;
        wait_start(1'b0, n);
        checks++; if (mul_sel !== 2'd2) begin errors++; $display("FAIL rot_first got %0d exp 2", mul_sel); end
        do_done(2, 64'd5);
        req_valid = 4'b0101;
        wait_start(1'b0, n);
        checks++; if (mul_sel !== 2'd0) begin errors++; $display("FAIL rot_wrap got %0d exp 0", mul_sel); end
        do_done(2, 64'd6);
        checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL rot_resp0 got %b exp 0001", resp_valid); end
        req_valid = 4'b0100;
        wait_start(1'b0, n);
        checks++; if (mul_sel !== 2'd2) begin errors++; $display("FAIL rot_then2 got %0d exp 2", mul_sel); end
        do_done(2, 64'd7);
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (jobs_done !== 32'd11) begin errors++; $display("FAIL rot_jobs got %0d exp 11", jobs_done); end
    endtask

    task automatic test_busy();
        mul_busy = 1'b1;
        req_valid = 4'b0001;
        repeat (5) @(negedge clk);
        checks++; if (mul_start !== 1'b0 || grant_valid !== 1'b0) begin errors++; $display("FAIL busy_hold got start %b gv %b exp 0 0", mul_start, grant_valid); end
        mul_busy = 1'b0;
        @(negedge clk);
        checks++; if (mul_start !== 1'b1 || mul_sel !== 2'd0) begin errors++; $display("FAIL busy_release got start %b sel %0d exp 1 0", mul_start, mul_sel); end
        do_done(2, 64'd9);
        checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL busy_resp got %b exp 0001", resp_valid); end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_spurious();
        mul_done = 1'b1; mul_cycles = 64'd55;
        @(negedge clk);
        mul_done = 1'b0; mul_cycles = '0;
        checks++; if (resp_valid !== 4'b0 || grant_valid !== 1'b0) begin errors++; $display("FAIL spur_resp got %b gv %b exp 0000 0", resp_valid, grant_valid); end
        @(negedge clk);
        checks++; if (jobs_done !== 32'd12 || resp_cycles !== 64'd9) begin errors++; $display("FAIL spur_state got jobs %0d cyc %0d exp 12 9", jobs_done, resp_cycles); end
    endtask

    task automatic test_watchdog();
        int n;
        int cnt;
        req_w = 4'b0010;
        wait_start(1'b1, n);
        checks++; if (n !== 1 || w_mul_sel !== 2'd1) begin errors++; $display("FAIL wd_grant got n %0d sel %0d exp 1 1", n, w_mul_sel); end
        cnt = 0;
        while (w_resp_valid == 4'b0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (cnt !== 17) begin errors++; $display("FAIL wd_delay got %0d exp 17", cnt); end
        checks++; if (w_resp_valid !== 4'b0010) begin errors++; $display("FAIL wd_owner got %b exp 0010", w_resp_valid); end
        checks++; if (w_resp_err !== 1'b1 || w_resp_cycles !== 64'd0) begin errors++; $display("FAIL wd_err got %b/%0d exp 1/0", w_resp_err, w_resp_cycles); end
        req_w = 4'b0000;
        @(negedge clk);
        checks++; if (w_jobs_done !== 32'd1 || w_grant_valid !== 1'b0) begin errors++; $display("FAIL wd_jobs got %0d gv %b exp 1 0", w_jobs_done, w_grant_valid); end
    endtask

    task automatic test_done_at_timeout();
        int n;
        req_w = 4'b0001;
        wait_start(1'b1, n);
        repeat (16) @(negedge clk);
        mul_done = 1'b1; mul_cycles = 64'd77;
        @(negedge clk);
        mul_done = 1'b0; mul_cycles = '0;
        checks++; if (w_resp_valid !== 4'b0001) begin errors++; $display("FAIL tie_resp got %b exp 0001", w_resp_valid); end
        checks++; if (w_resp_err !== 1'b0 || w_resp_cycles !== 64'd77) begin errors++; $display("FAIL tie_err got %b/%0d exp 0/77", w_resp_err, w_resp_cycles); end
        checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL tie_idle_main got %b exp 0000", resp_valid); end
        req_w = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int n;
        req_valid = 4'b0100;
        wait_start(1'b0, n);
        checks++; if (mul_sel !== 2'd2) begin errors++; $display("FAIL rstw_grant got %0d exp 2", mul_sel); end
        repeat (4) @(negedge clk);
        pulse_reset();
        checks++; if (resp_valid !== 4'b0 || grant_valid !== 1'b0 || mul_sel !== 2'd0) begin errors++; $display("FAIL rstw_outs got %b gv %b sel %0d exp 0000 0 0", resp_valid, grant_valid, mul_sel); end
        checks++; if (jobs_done !== 32'd0 || resp_cycles !== 64'd0) begin errors++; $display("FAIL rstw_regs got jobs %0d cyc %0d exp 0 0", jobs_done, resp_cycles); end
        req_valid = 4'b0101;
        wait_start(1'b0, n);
        checks++; if (n !== 1 || mul_sel !== 2'd0) begin errors++; $display("FAIL rstw_next got n %0d sel %0d exp 1 0", n, mul_sel); end
        do_done(2, 64'd3);
        checks++; if (resp_valid !== 4'b0001 || resp_cycles !== 64'd3) begin errors++; $display("FAIL rstw_resp got %b/%0d exp 0001/3", resp_valid, resp_cycles); end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_rotation();
        test_busy();
        test_spurious();
        test_watchdog();
        test_done_at_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
